fetch_unit: RTL and testbench

//  Instruction fetch stage. Producer side of the {pc, instr} interface that the decode stage consumes.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_queue.sv | 72 +++++++
 rtl/fetch_unit.sv | 111 +++++++++++
 tb/tb_fetch_unit.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-stage constants, queue entry type and PC helper.
package fetch_pkg;
    localparam int PC_WIDTH    = 12;
    localparam int INSTR_WIDTH = 32;
    localparam int FQ_DEPTH    = 4;
    localparam logic [PC_WIDTH-1:0]    RESET_PC  = 12'h000;
    localparam logic [INSTR_WIDTH-1:0] HALT_WORD = 32'h0000_0000;

    localparam logic [0:0] ST_FETCH = 1'b0;
    localparam logic [0:0] ST_DONE  = 1'b1;

    typedef struct packed {
        logic [PC_WIDTH-1:0]    pc;
        logic [INSTR_WIDTH-1:0] instr;
    } fq_entry_t;

    function automatic logic [PC_WIDTH-1:0] align_pc(input logic [PC_WIDTH-1:0] pc);
        return pc & {{(PC_WIDTH-2){1'b1}}, 2'b00};
    endfunction
endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO buffering fetched {pc, instr} entries; flush empties it in one cycle.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  fq_entry_t     push_data,
    input  logic          pop,
    output fq_entry_t     head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    fq_entry_t     mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          full_s;
    logic          empty_s;
    logic          push_ok_s;
    logic          pop_ok_s;

    // Occupancy flags and qualified push/pop; a pop frees the slot a same-cycle push needs when full.
    always_comb begin
        full_s    = (count_r == CW'(DEPTH));
        empty_s   = (count_r == {CW{1'b0}});
        pop_ok_s  = pop && !empty_s && !flush;
        push_ok_s = push && !flush && (!full_s || pop_ok_s);
    end

    // Pointer and occupancy state.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;
    assign full  = full_s;
    assign empty = empty_s;
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues imem reads under a queue credit limit and presents words to decode.
module fetch_unit
    import fetch_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    input  logic                   redirect_valid,
    input  logic [PC_WIDTH-1:0]    redirect_pc,
    output logic                   dec_valid,
    input  logic                   dec_ready,
    output logic [PC_WIDTH-1:0]    dec_pc,
    output logic [INSTR_WIDTH-1:0] dec_instr,
    output logic                   fetch_done
);
    localparam int CW = $clog2(FQ_DEPTH) + 1;

    logic [PC_WIDTH-1:0]    fetch_pc_r;
    logic [PC_WIDTH-1:0]    req_pc_r;
    logic                   inflight_r;
    logic                   kill_r;
    logic [0:0]             state_r;
    logic [CW-1:0]          count_s;
    logic                   full_s;
    logic                   empty_s;
    fq_entry_t              head_s;
    fq_entry_t              push_data_s;
    logic                   resp_s;
    logic                   halt_s;
    logic                   push_s;
    logic                   credit_ok_s;
    logic                   req_s;
    logic                   dec_valid_s;
    logic                   pop_s;
    logic [PC_WIDTH-1:0]    dec_pc_s;
    logic [INSTR_WIDTH-1:0] dec_instr_s;

    // Response qualification, credit check and handshake; redirect suppresses request, enqueue and dequeue.
    always_comb begin
        resp_s      = inflight_r && !kill_r && !redirect_valid;
        halt_s      = resp_s && (imem_rdata == HALT_WORD);
        push_s      = resp_s && !halt_s;
        push_data_s = '{pc: req_pc_r, instr: imem_rdata};
        credit_ok_s = ((count_s + {{(CW-1){1'b0}}, inflight_r}) < CW'(FQ_DEPTH)) && !full_s;
        req_s       = !rst && (state_r == ST_FETCH) && !redirect_valid && credit_ok_s;
        dec_valid_s = !rst && !empty_s && !redirect_valid;
        pop_s       = dec_valid_s && dec_ready;
    end

    // Decode payload reads as zero whenever nothing is buffered.
    always_comb begin
        if (!rst && !empty_s) begin
            dec_pc_s    = head_s.pc;
            dec_instr_s = head_s.instr;
        end else begin
            dec_pc_s    = {PC_WIDTH{1'b0}};
            dec_instr_s = {INSTR_WIDTH{1'b0}};
        end
    end

    // Fetch PC, in-flight tracking and FETCH/DONE state.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_r <= RESET_PC;
            req_pc_r   <= {PC_WIDTH{1'b0}};
            inflight_r <= 1'b0;
            kill_r     <= 1'b0;
            state_r    <= ST_FETCH;
        end else if (redirect_valid) begin
            fetch_pc_r <= align_pc(redirect_pc);
            inflight_r <= 1'b0;
            kill_r     <= 1'b0;
            state_r    <= ST_FETCH;
        end else begin
            inflight_r <= req_s;
            // A request racing the halt word belongs past end of program and must be dropped.
            kill_r     <= req_s && halt_s;
            if (req_s) begin
                req_pc_r <= fetch_pc_r;
            end
            if (req_s && !halt_s) begin
                fetch_pc_r <= fetch_pc_r + PC_WIDTH'(4);
            end
            if (halt_s) begin
                state_r <= ST_DONE;
            end
        end
    end

    fetch_queue #(.DEPTH(FQ_DEPTH)) u_fetch_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (push_s),
        .push_data (push_data_s),
        .pop       (pop_s),
        .head      (head_s),
        .count     (count_s),
        .full      (full_s),
        .empty     (empty_s)
    );

    assign imem_req   = req_s;
    assign imem_addr  = fetch_pc_r;
    assign dec_valid  = dec_valid_s;
    assign dec_pc     = dec_pc_s;
    assign dec_instr  = dec_instr_s;
    assign fetch_done = (state_r == ST_DONE);
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected stream is the program walk from each (re)start PC to its zero word.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [11:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [11:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [11:0] dec_pc;
    logic [31:0] dec_instr;
    logic        fetch_done;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_pc         (dec_pc),
        .dec_instr      (dec_instr),
        .fetch_done     (fetch_done)
    );

    logic [31:0] mem [0:1023];
    int          zero_idx = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    fq_entry_t   exp_q [$];
    fq_entry_t   mon_e;
    logic [11:0] exp_req_pc = 12'h000;
    int          req_count = 0;
    int          first_req_cyc = -1;
    int          xfer_cyc [$];

    // Synchronous memory: data one cycle after a request, garbage otherwise.
    always @(posedge clk) begin
        imem_rdata <= imem_req ? mem[imem_addr[11:2]] : $urandom;
        cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_zero(input logic [11:0] pc);
        mem[zero_idx] = $urandom | 32'h1;
        zero_idx = int'(pc[11:2]);
        mem[zero_idx] = 32'h0;
    endtask

    // Expected program: sequential words from start, wrapping, up to (excluding) the first zero word.
    task automatic restart(input logic [11:0] start);
        logic [11:0] p;
        fq_entry_t   e;
        exp_q.delete();
        xfer_cyc.delete();
        exp_req_pc    = start;
        first_req_cyc = -1;
        req_count     = 0;
        p = start;
        for (int i = 0; i < 1024; i++) begin
            if (mem[p[11:2]] == 32'h0) break;
            e.pc    = p;
            e.instr = mem[p[11:2]];
            exp_q.push_back(e);
            p = p + 12'd4;
        end
    endtask

    // Monitor: request address sequence and decode transfers against the scoreboard.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (imem_req === 1'b1) begin
                req_count++;
                if (first_req_cyc < 0) first_req_cyc = cyc;
                chk("req_addr", imem_addr, exp_req_pc);
                chk("req_after_done", fetch_done, 1'b0);
                exp_req_pc = exp_req_pc + 12'd4;
            end
            if (dec_valid === 1'b1 && dec_ready === 1'b1) begin
                xfer_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_xfer: got pc %0h instr %0h expected nothing", dec_pc, dec_instr);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("dec_pc", dec_pc, mon_e.pc);
                    chk("dec_instr", dec_instr, mon_e.instr);
                end
            end
        end
    end

    task automatic tick(input int mode);
        @(posedge clk);
        #1;
        if (mode == 2) dec_ready = ($urandom_range(0, 3) != 0);
        else           dec_ready = (mode == 1);
    endtask

    task automatic do_reset(input logic [11:0] zpc);
        @(posedge clk);
        #1;
        rst = 1'b1;
        redirect_valid = 1'b0;
        set_zero(zpc);
        restart(RESET_PC);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_imem_req", imem_req, 1'b0);
        chk("rst_dec_valid", dec_valid, 1'b0);
        chk("rst_dec_pc", dec_pc, 12'h000);
        chk("rst_dec_instr", dec_instr, 32'h0);
        chk("rst_fetch_done", fetch_done, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic do_redirect(input logic [11:0] pc, input logic [11:0] zpc);
        logic [11:0] apc;
        apc = pc & 12'hFFC;
        @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_pc = pc;
        set_zero(zpc);
        restart(apc);
        @(negedge clk);
        chk("redir_dec_valid", dec_valid, 1'b0);
        chk("redir_imem_req", imem_req, 1'b0);
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("post_redir_valid", dec_valid, 1'b0);
        chk("post_redir_req", imem_req, 1'b1);
        chk("post_redir_addr", imem_addr, apc);
        chk("post_redir_done", fetch_done, 1'b0);
    endtask

    task automatic run_until_done(input int mode, input int limit);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            tick(mode);
            if (fetch_done === 1'b1 && exp_q.size() == 0 && dec_valid === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("phase_done", ok, 1'b1);
        chk("leftover", exp_q.size(), 0);
        repeat (3) begin
            tick(mode);
            @(negedge clk);
            chk("idle_req", imem_req, 1'b0);
            chk("idle_valid", dec_valid, 1'b0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          found;
        logic [11:0] s;
        logic [11:0] zpc;
        int          off;

        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 12'h000;
        dec_ready = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom | 32'h1;

        // Four words then a halt word at 0x010, decode always ready.
        dec_ready = 1'b1;
        do_reset(12'h010);
        run_until_done(1, 200);
        chk("t1_xfers", xfer_cyc.size(), 4);
        if (xfer_cyc.size() == 4) begin
            chk("t1_latency", xfer_cyc[0], first_req_cyc + 2);
            chk("t1_back_to_back", xfer_cyc[3], xfer_cyc[0] + 3);
        end

        // Backpressure: credit limit caps requests, head stays put.
        dec_ready = 1'b0;
        do_reset(12'h100);
        repeat (20) begin
            tick(0);
            @(negedge clk);
            if (dec_valid) chk("t2_head_stable", dec_pc, 12'h000);
        end
        chk("t2_req_count", req_count, FQ_DEPTH);
        chk("t2_valid_held", dec_valid, 1'b1);
        run_until_done(2, 2000);

        // Redirect with 3 queued entries and a zero word in flight.
        dec_ready = 1'b0;
        do_reset(12'h00C);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (imem_req === 1'b1 && imem_addr == 12'h00C) begin
                found = 1'b1;
                break;
            end
        end
        chk("t4_saw_req_c", found, 1'b1);
        do_redirect(12'h0A5, 12'h0C0);
        run_until_done(2, 1000);

        // Redirect out of DONE across the top of the address space.
        do_redirect(12'hFF8, 12'h008);
        run_until_done(2, 500);
        chk("t5_xfers", xfer_cyc.size(), 4);

        // Reset while the queue is full.
        dec_ready = 1'b0;
        do_reset(12'h200);
        repeat (10) tick(0);
        chk("t6_full_valid", dec_valid, 1'b1);
        do_reset(12'h020);
        run_until_done(2, 1000);

        // Random programs, some interrupted by a second redirect.
        for (int k = 0; k < 8; k++) begin
            s   = 12'($urandom);
            off = $urandom_range(1, 30);
            zpc = (s & 12'hFFC) + 12'(off * 4);
            do_redirect(s, zpc);
            repeat ($urandom_range(0, 15)) tick(2);
            if ($urandom_range(0, 1) == 1) begin
                s   = 12'($urandom);
                off = $urandom_range(1, 30);
                zpc = (s & 12'hFFC) + 12'(off * 4);
                do_redirect(s, zpc);
            end
            run_until_done(2, 1000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
